alu_iterative: RTL and testbench

Sequential ALU execution stage that consumes the 4-bit operation code produced by the ALU control decoder. It executes the encoded operation on two 32-bit operands under a start/done handshake. Logic and arithmetic operations complete in one cycle. Shifts run iteratively, one bit position per cycle, which replaces the single-cycle barrel shifter in the datapath for area-reduced builds.

---
 rtl/alu_iterative.sv | 130 +++++++++++++
 tb/tb_alu_iterative.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Sequential ALU stage: single-cycle logic/arithmetic, bit-serial shifts.
// Ports: clk, reset (sync, active-low), start_i/busy_o/done_o handshake,
// alu_operation_i, a_data_i, b_data_i, shamt_i -> result_o, zero_o, invalid_o.
module alu_iterative #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic [4:0]            shamt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  invalid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_ANDI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b1101;

    state_t                state;
    logic [DATA_WIDTH-1:0] work;
    logic [4:0]            cnt;
    logic                  shift_right;

    logic [DATA_WIDTH-1:0] comb_result;
    logic                  comb_invalid;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] work_next;

    // Shift codes pass B through here; this value is only committed
    // when shamt is zero, so no barrel shifter is needed.
    always_comb begin
        comb_result  = '0;
        comb_invalid = 1'b0;
        is_shift     = 1'b0;
        case (alu_operation_i)
            OP_ADD, OP_LW, OP_SW: comb_result = a_data_i + b_data_i;
            OP_SUB:  comb_result = a_data_i - b_data_i;
            OP_OR:   comb_result = a_data_i | b_data_i;
            OP_ORI:  comb_result = a_data_i | {16'h0, b_data_i[15:0]};
            OP_SRL, OP_SLL: begin
                comb_result = b_data_i;
                is_shift    = 1'b1;
            end
            OP_LUI:  comb_result = {b_data_i[15:0], 16'h0};
            OP_ANDI: comb_result = a_data_i & {16'h0, b_data_i[15:0]};
            OP_NOR:  comb_result = ~(a_data_i | b_data_i);
            OP_AND:  comb_result = a_data_i & b_data_i;
            default: comb_invalid = 1'b1;
        endcase
    end

    assign work_next = shift_right ? (work >> 1) : (work << 1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            result_o    <= '0;
            zero_o      <= 1'b0;
            invalid_o   <= 1'b0;
            cnt         <= '0;
            work        <= '0;
            shift_right <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        if (is_shift && shamt_i != 5'd0) begin
                            work        <= b_data_i;
                            cnt         <= shamt_i;
                            shift_right <= (alu_operation_i == OP_SRL);
                            state       <= SHIFT;
                            busy_o      <= 1'b1;
                            done_o      <= 1'b0;
                        end else begin
                            result_o  <= comb_result;
                            zero_o    <= (comb_result == '0);
                            invalid_o <= comb_invalid;
                            state     <= DONE;
                            done_o    <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        done_o <= 1'b0;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result_o  <= work_next;
                        zero_o    <= (work_next == '0);
                        invalid_o <= 1'b0;
                        state     <= DONE;
                        busy_o    <= 1'b0;
                        done_o    <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative.
// Drives on negedge, samples on negedge, immediate assertions per check.
module tb_alu_iterative;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_data_i;
    logic [31:0] b_data_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        zero_o;
    logic        invalid_o;

    int checks = 0;
    int errors = 0;
    int lat;
    int busyc;
    int dones;
    int first_done;

    alu_iterative dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_data_i        (a_data_i),
        .b_data_i        (b_data_i),
        .shamt_i         (shamt_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .invalid_o       (invalid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues one op, waits for done (bounded),
    // then checks result, flags, latency, busy cycles and pulse width.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [31:0] exp_r,
                          input logic exp_z, input logic exp_inv,
                          input int exp_lat, input int exp_busy);
        alu_operation_i = op;
        a_data_i = a;
        b_data_i = b;
        shamt_i = sh;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        lat = 0;
        busyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy_o) busyc++;
        end while (!done_o && lat < 40);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, busyc, exp_busy);
        chk({tag, "_busy_at_done"}, {31'b0, busy_o}, 32'd0);
        chk({tag, "_res"}, result_o, exp_r);
        chk({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp_z});
        chk({tag, "_inv"}, {31'b0, invalid_o}, {31'b0, exp_inv});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        start_i = 1'b0;
        alu_operation_i = 4'b0;
        a_data_i = '0;
        b_data_i = '0;
        shamt_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_res", result_o, 32'd0);
        chk("rst_zero", {31'b0, zero_o}, 32'd0);
        chk("rst_inv", {31'b0, invalid_o}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("add", 4'b0000, 32'h7FFFFFFF, 32'h1, 5'd0,
               32'h80000000, 1'b0, 1'b0, 1, 0);
        run_op("sub", 4'b0001, 32'd5, 32'd5, 5'd0,
               32'h0, 1'b1, 1'b0, 1, 0);
        run_op("sll31", 4'b0101, 32'h0, 32'h1, 5'd31,
               32'h80000000, 1'b0, 1'b0, 32, 31);
        run_op("srl4", 4'b0100, 32'h0, 32'h80000000, 5'd4,
               32'h08000000, 1'b0, 1'b0, 5, 4);
        run_op("sll0", 4'b0101, 32'h0, 32'hDEADBEEF, 5'd0,
               32'hDEADBEEF, 1'b0, 1'b0, 1, 0);
        run_op("srl_out", 4'b0100, 32'h0, 32'h00000003, 5'd2,
               32'h0, 1'b1, 1'b0, 3, 2);
        run_op("lui", 4'b0110, 32'h0, 32'h1234ABCD, 5'd7,
               32'hABCD0000, 1'b0, 1'b0, 1, 0);
        run_op("ori", 4'b0011, 32'hFFFF0000, 32'hFFFF1234, 5'd0,
               32'hFFFF1234, 1'b0, 1'b0, 1, 0);
        run_op("andi", 4'b0111, 32'hFFFFFFFF, 32'hFFFF00F0, 5'd0,
               32'h000000F0, 1'b0, 1'b0, 1, 0);
        run_op("nor", 4'b1100, 32'h0, 32'h0, 5'd0,
               32'hFFFFFFFF, 1'b0, 1'b0, 1, 0);
        run_op("and", 4'b1101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,
               32'hF000F000, 1'b0, 1'b0, 1, 0);
        run_op("or", 4'b0010, 32'h0000000F, 32'h000000F0, 5'd0,
               32'h000000FF, 1'b0, 1'b0, 1, 0);
        run_op("lw", 4'b1000, 32'd100, 32'd4, 5'd0,
               32'd104, 1'b0, 1'b0, 1, 0);
        run_op("sw", 4'b1001, 32'hFFFFFFFF, 32'h1, 5'd0,
               32'h0, 1'b1, 1'b0, 1, 0);
        run_op("inv1111", 4'b1111, 32'h1, 32'h2, 5'd0,
               32'h0, 1'b1, 1'b1, 1, 0);
        run_op("inv1010", 4'b1010, 32'h12345678, 32'h9, 5'd3,
               32'h0, 1'b1, 1'b1, 1, 0);
        run_op("after_inv", 4'b0000, 32'h3, 32'h4, 5'd0,
               32'h7, 1'b0, 1'b0, 1, 0);

        // Start pulsed mid-shift with new operands must be dropped.
        alu_operation_i = 4'b0100;
        a_data_i = 32'h0;
        b_data_i = 32'hF0000000;
        shamt_i = 5'd10;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        dones = 0;
        first_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) begin
                alu_operation_i = 4'b0000;
                a_data_i = 32'h1;
                b_data_i = 32'h1;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                dones++;
                if (first_done == 0) begin
                    first_done = c;
                    chk("ign_res", result_o, 32'h003C0000);
                end
            end
        end
        chk("ign_dones", dones, 32'd1);
        chk("ign_lat", first_done, 32'd11);

        // Reset in the middle of a shift aborts it.
        alu_operation_i = 4'b0101;
        b_data_i = 32'h1;
        shamt_i = 5'd20;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", {31'b0, busy_o}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        chk("abort_res", result_o, 32'h0);
        chk("abort_zero", {31'b0, zero_o}, 32'd0);
        chk("abort_done", {31'b0, done_o}, 32'd0);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("abort_nodone", dones, 32'd0);
        run_op("post_rst", 4'b0000, 32'd2, 32'd3, 5'd0,
               32'd5, 1'b0, 1'b0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
